// File: rtl/toggle_pulse_decoder.sv
// Toggle-signalling receiver: synchronises tog_in, optionally debounces it, and emits one strobe per committed flip.
// Define TOGGLE_PULSE_DECODER_DEBOUNCE_EN to enable the debounce FSM; otherwise every synchronised flip commits.
module toggle_pulse_decoder #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DEBOUNCE_W      = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  output logic             level,
  output logic             pulse,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             evt_pending,
  input  logic             evt_ack,
  output logic             overrun
);

  // Elaboration-time configuration checks.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("toggle_pulse_decoder: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("toggle_pulse_decoder: DEBOUNCE_CYCLES must be >= 2");
  end
  if (((DEBOUNCE_CYCLES - 1) >> DEBOUNCE_W) != 0) begin : g_bad_debw
    $error("toggle_pulse_decoder: DEBOUNCE_W too narrow for DEBOUNCE_CYCLES-1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   commit;

  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic             pend_q, pend_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef TOGGLE_PULSE_DECODER_DEBOUNCE_EN
  typedef enum logic {
    ST_STABLE,
    ST_CHECK
  } deb_state_e;

  localparam logic [DEBOUNCE_W-1:0] DEB_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

  deb_state_e            state_q, state_d;
  logic [DEBOUNCE_W-1:0] deb_cnt_q, deb_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_STABLE;
      deb_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // The counter holds how many consecutive samples of s have disagreed with level.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    commit    = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (s != level_q) begin
          state_d   = ST_CHECK;
          deb_cnt_d = DEBOUNCE_W'(1);
        end
      end
      ST_CHECK: begin
        if (s == level_q) begin
          state_d   = ST_STABLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          commit    = 1'b1;
          state_d   = ST_STABLE;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEBOUNCE_W'(1);
        end
      end
      default: begin
        state_d   = ST_STABLE;
        deb_cnt_d = '0;
      end
    endcase
  end
`else
  always_comb begin
    commit = (s != level_q);
  end
`endif

  always_comb begin
    level_d   = level_q;
    pulse_d   = commit;
    rise_d    = commit & s;
    fall_d    = commit & ~s;
    evt_cnt_d = evt_cnt_q;
    pend_d    = pend_q;
    ovr_d     = ovr_q;
    if (commit) begin
      level_d   = s;
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
      pend_d    = 1'b1;
      // A same-edge ack consumes the old event, so only an unacked one overruns.
      if (pend_q && !evt_ack) begin
        ovr_d = 1'b1;
      end
    end else if (evt_ack) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      evt_cnt_q <= '0;
      pend_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      evt_cnt_q <= evt_cnt_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
    end
  end

  assign level       = level_q;
  assign pulse       = pulse_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign evt_cnt     = evt_cnt_q;
  assign evt_pending = pend_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_toggle_pulse_decoder.sv
// Bench for toggle_pulse_decoder: directed scenarios plus a randomized run against a sample-history reference model.
module tb_toggle_pulse_decoder;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int DW   = 4;
  localparam int CW   = 4;
`ifdef TOGGLE_PULSE_DECODER_DEBOUNCE_EN
  localparam int D_EFF = DEB;
`else
  localparam int D_EFF = 1;
`endif
  localparam int LAT  = SYNC + D_EFF;
  localparam int HLEN = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tog_in = 1'b0;
  logic evt_ack = 1'b0;
  logic level, pulse, rise, fall, evt_pending, overrun;
  logic [CW-1:0] evt_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  toggle_pulse_decoder #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .DEBOUNCE_W(DW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tog_in(tog_in),
    .level(level),
    .pulse(pulse),
    .rise(rise),
    .fall(fall),
    .evt_cnt(evt_cnt),
    .evt_pending(evt_pending),
    .evt_ack(evt_ack),
    .overrun(overrun)
  );

  // Reference model: a commit happens when the last D_EFF synchronised samples since
  // the previous commit/reset all disagree with the committed level.
  bit hist [HLEN];
  int n = 0;
  int rst_edge = 0;
  int last_commit = 0;
  bit m_level, m_pulse, m_rise, m_fall, m_pend, m_ovr;
  int m_cnt;

  function automatic bit s_at(int k);
    if (k - SYNC > rst_edge) return hist[(k - SYNC) % HLEN];
    return 1'b0;
  endfunction

  task automatic step();
    bit s;
    bit commit;
    @(posedge clk);
    n++;
    hist[n % HLEN] = tog_in;
    if (!rst) begin
      rst_edge = n; last_commit = n;
      m_level = 0; m_pulse = 0; m_rise = 0; m_fall = 0;
      m_pend = 0; m_ovr = 0; m_cnt = 0;
    end else begin
      s = s_at(n);
      commit = 1'b1;
      for (int j = 0; j < D_EFF; j++)
        if (n - j <= last_commit || s_at(n - j) == m_level) commit = 1'b0;
      if (commit) begin
        if (m_pend && !evt_ack) m_ovr = 1'b1;
        m_pend = 1'b1; m_level = s; m_pulse = 1'b1; m_rise = s; m_fall = !s;
        m_cnt = (m_cnt + 1) % (1 << CW);
        last_commit = n;
      end else begin
        m_pulse = 0; m_rise = 0; m_fall = 0;
        if (evt_ack) m_pend = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; tog_in = 1'b0; evt_ack = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_reset();
    rst = 1'b0; tog_in = 1'b1; evt_ack = 1'b1;
    repeat (3) step();
    checks++;
    if ({level, pulse, rise, fall, evt_cnt, evt_pending, overrun} !== '0) begin
      failures++;
      $display("FAIL reset_state: got %b expected all zero",
               {level, pulse, rise, fall, evt_cnt, evt_pending, overrun});
    end
    evt_ack = 1'b0;
  endtask

  task automatic test_first_rise();
    bit early;
    do_reset();
    tog_in = 1'b1;
    early = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      step();
      if (pulse !== 1'b0 || level !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin failures++; $display("FAIL rise_early: got early commit expected none before edge %0d", LAT); end
    step();
    checks++;
    if (level !== 1'b1) begin failures++; $display("FAIL rise_level: got %b expected 1", level); end
    checks++;
    if ({pulse, rise, fall} !== 3'b110) begin failures++; $display("FAIL rise_strobes: got %b expected 110", {pulse, rise, fall}); end
    checks++;
    if (evt_cnt !== CW'(1)) begin failures++; $display("FAIL rise_cnt: got %0d expected 1", evt_cnt); end
    checks++;
    if (evt_pending !== 1'b1) begin failures++; $display("FAIL rise_pending: got %b expected 1", evt_pending); end
    step();
    checks++;
    if (pulse !== 1'b0 || level !== 1'b1) begin
      failures++; $display("FAIL pulse_width: got pulse=%b level=%b expected pulse=0 level=1", pulse, level);
    end
  endtask

  task automatic test_glitch();
    int pulses, rises;
    int exp_p;
    do_reset();
    pulses = 0; rises = 0;
    tog_in = 1'b1;
    step(); step();
    tog_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pulse === 1'b1) pulses++;
      if (rise === 1'b1) rises++;
    end
    exp_p = (D_EFF <= 2) ? 2 : 0;
    checks++;
    if (pulses != exp_p) begin failures++; $display("FAIL glitch_pulses: got %0d expected %0d", pulses, exp_p); end
    checks++;
    if (rises != exp_p / 2) begin failures++; $display("FAIL glitch_rises: got %0d expected %0d", rises, exp_p / 2); end
    checks++;
    if (evt_cnt !== CW'(exp_p)) begin failures++; $display("FAIL glitch_cnt: got %0d expected %0d", evt_cnt, exp_p); end
    checks++;
    if (level !== 1'b0) begin failures++; $display("FAIL glitch_level: got %b expected 0", level); end
  endtask

  task automatic test_wrap();
    int pulses;
    do_reset();
    pulses = 0;
    for (int e = 0; e < 17; e++) begin
      tog_in = ~tog_in;
      for (int i = 0; i < 8; i++) begin
        step();
        if (pulse === 1'b1) pulses++;
      end
      evt_ack = 1'b1; step();
      evt_ack = 1'b0; step();
    end
    checks++;
    if (pulses != 17) begin failures++; $display("FAIL wrap_pulses: got %0d expected 17", pulses); end
    checks++;
    if (evt_cnt !== CW'(1)) begin failures++; $display("FAIL wrap_cnt: got %0d expected 1", evt_cnt); end
    checks++;
    if (overrun !== 1'b0 || evt_pending !== 1'b0) begin
      failures++; $display("FAIL wrap_flags: got ovr=%b pend=%b expected 0 0", overrun, evt_pending);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    tog_in = 1'b1;
    repeat (LAT + 2) step();
    checks++;
    if ({evt_pending, overrun} !== 2'b10) begin failures++; $display("FAIL ovr_first: got %b expected 10", {evt_pending, overrun}); end
    tog_in = 1'b0;
    repeat (LAT) step();
    checks++;
    if ({pulse, fall, evt_pending, overrun} !== 4'b1111) begin
      failures++; $display("FAIL ovr_second: got %b expected 1111", {pulse, fall, evt_pending, overrun});
    end
    step(); step();
    evt_ack = 1'b1; step();
    evt_ack = 1'b0;
    checks++;
    if ({evt_pending, overrun} !== 2'b01) begin failures++; $display("FAIL ovr_ack: got %b expected 01", {evt_pending, overrun}); end
    repeat (3) step();
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    rst = 1'b0; step(); rst = 1'b1;
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_reset: got %b expected 0", overrun); end
  endtask

  task automatic test_ack_coincide();
    do_reset();
    tog_in = 1'b1;
    repeat (LAT + 2) step();
    tog_in = 1'b0;
    repeat (LAT - 1) step();
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    checks++;
    if ({pulse, evt_pending, overrun} !== 3'b110) begin
      failures++; $display("FAIL ack_coincide: got pulse/pend/ovr=%b expected 110", {pulse, evt_pending, overrun});
    end
  endtask

  task automatic test_reset_midcheck();
    bit early;
    do_reset();
    tog_in = 1'b1;
    repeat ((D_EFF >= 3) ? 4 : LAT - 1) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if ({level, pulse, evt_cnt} !== '0) begin
      failures++; $display("FAIL midcheck_reset: got level=%b pulse=%b cnt=%0d expected 0 0 0", level, pulse, evt_cnt);
    end
    early = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      step();
      if (pulse !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin failures++; $display("FAIL midcheck_early: got early pulse expected none"); end
    step();
    checks++;
    if ({pulse, rise, evt_cnt} !== {2'b11, CW'(1)}) begin
      failures++; $display("FAIL midcheck_rise: got pulse=%b rise=%b cnt=%0d expected 1 1 1", pulse, rise, evt_cnt);
    end
  endtask

  task automatic test_random();
    int hold;
    logic [CW+5:0] exp_v, act_v;
    do_reset();
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        tog_in = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      evt_ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) != 0);
      step();
      exp_v = {m_level, m_pulse, m_rise, m_fall, CW'(m_cnt), m_pend, m_ovr};
      act_v = {level, pulse, rise, fall, evt_cnt, evt_pending, overrun};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL random_outputs @%0d: got %b expected %b (level,pulse,rise,fall,cnt,pend,ovr)", i, act_v, exp_v);
      end
    end
    rst = 1'b1; evt_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_rise();
    test_glitch();
    test_wrap();
    test_overrun();
    test_ack_coincide();
    test_reset_midcheck();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
